// File: rtl/spi_modport.sv
// Mode-0 SPI master: one 8-bit word per start request, MSB first, with a fixed
// SCLK divider. The byte received on miso is returned on rx_data when the transfer ends.
module spi_modport #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DIV_TC = DW'(HALF - 1);

    typedef enum logic {IDLE, TRANSFER} state_t;

    state_t        state, state_nx;
    logic [7:0]    tx_shift, rx_reg;
    logic [DW-1:0] div_cnt;
    logic [4:0]    edge_cnt;
    logic          accept, tick, last;

    // mosi comes straight from the shift register MSB. The register is cleared
    // at the end of a transfer, so mosi idles low.
    assign mosi = tx_shift[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tick     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = TRANSFER;
                end
            end
            TRANSFER: begin
                tick = (div_cnt == DIV_TC);
                last = tick && (edge_cnt == 5'd15);
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= 8'h00;
            rx_reg   <= 8'h00;
            rx_data  <= 8'h00;
            div_cnt  <= '0;
            edge_cnt <= 5'd0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tx_shift <= tx_data;
                cs_n     <= 1'b0;
                busy     <= 1'b1;
                sclk     <= 1'b0;
                div_cnt  <= '0;
                edge_cnt <= 5'd0;
            end else if (state == TRANSFER) begin
                if (tick) begin
                    div_cnt  <= '0;
                    edge_cnt <= edge_cnt + 5'd1;
                    if (last) begin
                        sclk     <= 1'b0;
                        cs_n     <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rx_data  <= rx_reg;
                        tx_shift <= 8'h00;
                    end else if (!sclk) begin
                        // rising edge: sample miso
                        sclk   <= 1'b1;
                        rx_reg <= {rx_reg[6:0], miso};
                    end else begin
                        // falling edge: present the next bit
                        sclk     <= 1'b0;
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_modport.sv
// Bench for spi_modport. A CLK_DIV=4 instance talks to a behavioural mode-0 slave,
// and a CLK_DIV=2 instance has its mosi looped back to miso.
module tb_spi_modport;
    logic       clk = 1'b0;
    logic       rst, start, miso;
    logic [7:0] tx_data, rx_data;
    logic       busy, done, sclk, mosi, cs_n;
    logic       start2;
    logic [7:0] tx2, rx2;
    logic       busy2, done2, sclk2, mosi2, cs2_n;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    spi_modport #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
        .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_modport #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .rx_data(rx2),
        .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .cs_n(cs2_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] exp_rx);
        chk({tag, "_sclk"}, sclk, 1'b0);
        chk({tag, "_cs_n"}, cs_n, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_mosi"}, mosi, 1'b0);
        chk({tag, "_rx"}, rx_data, exp_rx);
    endtask

    // A single transfer on the CLK_DIV=4 instance, with the slave returning sl.
    // mode 0 is a plain transfer, mode 1 re-pulses start at bit 3, and mode 2
    // aborts with rst after 5 rises. With chain set, start is raised in the done cycle.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input int mode,
                        input logic chain, input logic [7:0] nxt, input logic prestarted);
        int rises, falls, busy_cnt, cs_cnt, cyc;
        logic prev, fin, clr_start;
        logic [7:0] got_mosi;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
            tx_data = tx;
        end
        miso = sl[7];
        @(posedge clk); #1;
        start = 1'b0;
        tx_data = 8'($urandom_range(0, 255));
        chk("accept_cs_n", cs_n, 1'b0);
        chk("accept_busy", busy, 1'b1);
        chk("accept_mosi", mosi, tx[7]);
        rises = 0; falls = 0; busy_cnt = 0; cs_cnt = 0;
        prev = 1'b0; fin = 1'b0; got_mosi = 8'h00; clr_start = 1'b0;
        for (cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (busy) busy_cnt++;
            if (!cs_n) cs_cnt++;
            if (sclk && !prev) begin
                got_mosi = {got_mosi[6:0], mosi};
                rises++;
                if (mode == 1 && rises == 3) begin
                    start = 1'b1;
                    tx_data = 8'hFF;
                    clr_start = 1'b1;
                end
                if (mode == 2 && rises == 5) begin
                    #2 rst = 1'b1;
                    #1 check_idle("abort", 8'h00);
                    @(negedge clk) rst = 1'b0;
                    return;
                end
            end
            if (!sclk && prev) begin
                falls++;
                if (falls < 8) miso = sl[7 - falls];
            end
            if (done) begin
                fin = 1'b1;
                if (chain) begin
                    start = 1'b1;
                    tx_data = nxt;
                end
            end
            prev = sclk;
            if (!fin) begin
                @(posedge clk); #1;
                if (clr_start) begin
                    start = 1'b0;
                    clr_start = 1'b0;
                end
            end
        end
        chk("done_seen", fin, 1'b1);
        chk("mosi_bits", got_mosi, tx);
        chk("busy_len", busy_cnt, 32);
        chk("cs_low_len", cs_cnt, 32);
        chk("rx_data", rx_data, sl);
        chk("end_cs_n", cs_n, 1'b1);
        chk("end_busy", busy, 1'b0);
        if (!chain) begin
            @(posedge clk); #1;
            chk("done_single", done, 1'b0);
            chk("rx_stable", rx_data, sl);
        end
    endtask

    task automatic xfer2(input logic [7:0] tx);
        int busy_cnt, bad, cyc;
        logic prev, fin;
        @(negedge clk);
        start2 = 1'b1;
        tx2 = tx;
        @(posedge clk); #1;
        start2 = 1'b0;
        busy_cnt = 0; bad = 0; fin = 1'b0; prev = sclk2;
        for (cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (cyc > 0 && sclk2 == prev) bad++;
            if (busy2) busy_cnt++;
            if (done2) fin = 1'b1;
            prev = sclk2;
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        chk("d2_done", fin, 1'b1);
        chk("d2_sclk_toggle", bad, 0);
        chk("d2_busy_len", busy_cnt, 16);
        chk("d2_rx_loop", rx2, tx);
        chk("d2_cs_n", cs2_n, 1'b1);
    endtask

    initial begin
        logic [7:0] r_tx, r_sl;
        rst = 1'b0; start = 1'b0; tx_data = 8'h00; miso = 1'b0;
        start2 = 1'b0; tx2 = 8'h00;
        #3 rst = 1'b1;
        #1 check_idle("reset", 8'h00);
        chk("reset_d2_busy", busy2, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("post_reset", 8'h00);

        xfer(8'hA5, 8'h3C, 0, 1'b0, 8'h00, 1'b0);
        xfer(8'hA5, 8'h3C, 1, 1'b0, 8'h00, 1'b0);
        xfer(8'h00, 8'hFF, 0, 1'b1, 8'hFF, 1'b0);
        xfer(8'hFF, 8'hFF, 0, 1'b0, 8'h00, 1'b1);

        xfer(8'hC3, 8'h96, 2, 1'b0, 8'h00, 1'b0);
        repeat (40) @(posedge clk);
        #1 check_idle("after_abort", 8'h00);
        xfer(8'h5A, 8'h81, 0, 1'b0, 8'h00, 1'b0);

        repeat (6) begin
            r_tx = 8'($urandom_range(0, 255));
            r_sl = 8'($urandom_range(0, 255));
            xfer(r_tx, r_sl, 0, 1'b0, 8'h00, 1'b0);
        end

        xfer2(8'h81);
        repeat (3) xfer2(8'($urandom_range(0, 255)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
